fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front-end for the single-cycle MIPS core. It owns the fetch PC, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small FIFO. The datapath consumes instructions through a valid/ready port and redirects fetch on taken branches, J/JAL and JR.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- imem_req  out  1  read request; combinational; 0 while rst_n low.
- imem_addr  out  32  word address of the request; equals fetch_pc; bits [1:0] always 0.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; in order; ≥1 cycle after the grant.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_data  out  32  head instruction.
- inst_pc  out  32  address the head instruction was fetched from.
- inst_ready  in  1  datapath consumes the head.
- redirect_valid  in  1  single-cycle fetch redirect.
- redirect_pc  in  32  new fetch PC; bits [1:0] are forced to 0.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- States: IDLE (no request outstanding), WAIT (one request outstanding), DROP (outstanding response must be discarded). At most one request is outstanding.
- Signal definitions:
  - push = state==WAIT && imem_rvalid && !redirect_valid.
  - pop = inst_valid && inst_ready.
  - next_count = count + push − pop.
- imem_req = rst_n && !redirect_valid && (state==IDLE || (state==WAIT && imem_rvalid)) && next_count < DEPTH.
- Grant (imem_req && imem_gnt):
  - entry PC latched = fetch_pc.
  - fetch_pc += 4, wrapping modulo 2^32.
  - state → WAIT.
- WAIT with imem_rvalid:
  - push {latched PC, imem_rdata}.
  - state → IDLE, unless a new grant occurs in the same cycle, in which case state stays WAIT.
- Redirect (has priority over everything):
  - Clears the FIFO: count → 0, any pop in the same cycle is ignored.
  - fetch_pc → {redirect_pc[31:2], 2'b00}.
  - No request is issued in the redirect cycle.
  - State transitions:
    - IDLE → IDLE.
    - WAIT with imem_rvalid: discard the response, → IDLE.
    - WAIT without imem_rvalid → DROP.
    - DROP → DROP, with fetch_pc updated again.
- DROP: imem_rvalid discards the data, → IDLE. No requests are issued in DROP.
- In IDLE, imem_rvalid is ignored. This covers stray responses after a reset.
- FIFO full: no request is issued, so an accepted response always has a slot.
- Empty FIFO: inst_valid=0, and inst_data/inst_pc hold their last values.
- Reset values: state IDLE, fetch_pc=RESET_PC, count 0, inst_valid 0, inst_data 0, inst_pc 0, imem_req 0.

## Timing
- First imem_req is in the first cycle with rst_n high.
- Response to output: an instruction pushed at edge N is visible (inst_valid=1) from edge N onward, i.e. in the cycle after imem_rvalid. No bypass path.
- Zero-wait memory (gnt always 1, rvalid 1 cycle after grant): sustained 1 instruction/cycle with inst_ready held high.
- Redirect at cycle R from IDLE: request for redirect_pc at R+1; its instruction is valid at R+3 with 1-cycle memory.
- Redirect from WAIT without rvalid: the next request is in the cycle after the pending response arrives.
- Asynchronous reset mid-transaction: all state clears immediately. The memory side must also be reset.
- Paths from imem_rvalid and inst_ready to imem_req are combinational. inst_* outputs come from registers.

## Structure
- Shared package mips_pkg holds:
  - fetch state encoding (IDLE=2'd0, WAIT=2'd1, DROP=2'd2).
  - RESET_PC default.
  - fetch-entry type {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: synchronous FIFO of DEPTH 64-bit entries with push, pop and flush (flush wins), count output and head outputs.
- The state machine, fetch_pc and request logic live in fetch_queue.

## Test plan
- Reset then zero-wait memory returning data = address, inst_ready=1 → inst_pc/inst_data = 0,4,8,… on consecutive cycles after a 2-cycle startup.
- inst_ready=0 with DEPTH=4 → exactly 4 grants, then imem_req=0, fifo_count=4. One pop → exactly one new request.
- Redirect to 32'h0000_0103 while WAIT, with rvalid 3 cycles later → FIFO emptied, response discarded, next imem_addr=32'h0000_0100, and the first delivered inst_pc=32'h100.
- Redirect in the same cycle as imem_rvalid and pop → data discarded, count 0, state IDLE, request for redirect_pc in the next cycle.
- Redirect to 32'hFFFF_FFFC → fetch addresses FFFF_FFFC then 0000_0000 (wrap).
- rst_n asserted in WAIT with 2 entries queued → outputs immediately at reset values. A stray imem_rvalid after release is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the MIPS fetch front-end: fetch FSM encoding, reset PC, FIFO entry.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush beats push and pop.
// The head is held in its own register so it keeps the last value when empty.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     head_valid_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nxt;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  head_q, head_d;
  logic          valid_q, valid_d;
  logic          do_push, do_pop;

  // Pointer, occupancy and head-register next-state.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    head_d     = head_q;
    rd_ptr_nxt = rd_ptr_q + AW'(1);
    do_pop     = pop_i && valid_q && !flush_i;
    do_push    = push_i && !flush_i && ((count_q != CW'(DEPTH)) || do_pop);

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_nxt;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (do_pop) begin
        if (count_q > CW'(1)) begin
          head_d = mem_q[rd_ptr_nxt];
        end else if (do_push) begin
          head_d = push_data_i;
        end
      end else if (!valid_q && do_push) begin
        head_d = push_data_i;
      end
    end
    valid_d = (count_d != '0);
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o      = count_q;
  assign head_valid_o = valid_q;
  assign head_o       = head_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues one outstanding word read
// at a time, buffers responses in fetch_fifo and handles redirects.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned NW = CW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   entry_pc_q, entry_pc_d;
  logic          push_c, pop_c, req_c, grant_c;
  logic [NW-1:0] next_count_c;
  logic          fifo_valid;
  logic [CW-1:0] fifo_cnt;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;

  // Push/pop qualifiers and the occupancy the FIFO will have after this edge.
  always_comb begin
    push_c       = (state_q == FETCH_WAIT) && imem_rvalid && !redirect_valid;
    pop_c        = fifo_valid && inst_ready;
    next_count_c = NW'(fifo_cnt) + NW'(push_c) - NW'(pop_c);
  end

  // Fetch FSM next-state, fetch PC and request generation.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    entry_pc_d = entry_pc_q;
    req_c      = 1'b0;
    grant_c    = 1'b0;

    if (rst_n && !redirect_valid && (next_count_c < NW'(DEPTH))) begin
      req_c = (state_q == FETCH_IDLE) || ((state_q == FETCH_WAIT) && imem_rvalid);
    end
    grant_c = req_c && imem_gnt;

    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      case (state_q)
        FETCH_IDLE: state_d = FETCH_IDLE;
        // A response arriving with the redirect is the one being dropped, so
        // there is nothing left to wait for.
        FETCH_WAIT: state_d = imem_rvalid ? FETCH_IDLE : FETCH_DROP;
        FETCH_DROP: state_d = imem_rvalid ? FETCH_IDLE : FETCH_DROP;
        default:    state_d = FETCH_IDLE;
      endcase
    end else begin
      if (grant_c) begin
        entry_pc_d = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      case (state_q)
        FETCH_IDLE: if (grant_c) state_d = FETCH_WAIT;
        FETCH_WAIT: if (imem_rvalid) state_d = grant_c ? FETCH_WAIT : FETCH_IDLE;
        FETCH_DROP: if (imem_rvalid) state_d = FETCH_IDLE;
        default:    state_d = FETCH_IDLE;
      endcase
    end
  end

  // FSM state, fetch PC and PC of the outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= word_align(RESET_PC);
      entry_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      entry_pc_q <= entry_pc_d;
    end
  end

  assign push_entry = '{pc: entry_pc_q, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push_c),
    .push_data_i  (push_entry),
    .pop_i        (pop_c),
    .flush_i      (redirect_valid),
    .count_o      (fifo_cnt),
    .head_valid_o (fifo_valid),
    .head_o       (fifo_head)
  );

  assign imem_req   = req_c;
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = fifo_valid;
  assign inst_data  = fifo_head.instr;
  assign inst_pc    = fifo_head.pc;
  assign fifo_count = fifo_cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus a wrap-around sequence.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        rdv;
    logic [31:0] rdpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s [%0d] got=%h want=%h", nm, idx, got, exp);
    end
  endtask

  // Inputs for one cycle followed by the outputs expected before that cycle's edge.
  task automatic add(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic rdv, input logic [31:0] rdp,
                     input logic e_req, input logic [31:0] e_addr, input logic e_v,
                     input logic [31:0] e_pc, input logic [31:0] e_data, input logic [2:0] e_cnt);
    vec_t t;
    t.rst = r; t.gnt = g; t.rv = rv; t.rdata = rd; t.rdy = rdy; t.rdv = rdv; t.rdpc = rdp;
    t.e_req = e_req; t.e_addr = e_addr; t.e_v = e_v; t.e_pc = e_pc; t.e_data = e_data;
    t.e_cnt = e_cnt;
    vecs.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] gq[$];
    logic [31:0] dpc[$];
    logic [31:0] ddat[$];
    logic [31:0] exp_g[4];
    logic [31:0] exp_p[3];

    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // reset
    add(0,0,0,0,0,0,0,            0,32'h0,0,0,0,0);
    add(0,0,0,0,0,0,0,            0,32'h0,0,0,0,0);
    // zero-wait stream, data = address
    add(1,1,0,0,1,0,0,            1,32'h0,0,0,0,0);
    add(1,1,1,0,1,0,0,            1,32'h4,0,0,0,0);
    for (int k = 2; k < 8; k++)
      add(1,1,1,32'(4*(k-1)),1,0,0, 1,32'(4*k),1,32'(4*(k-2)),32'(4*(k-2)),3'd1);
    // consumer stalled: fill to DEPTH, then one pop allows exactly one request
    add(1,1,1,32'd28,0,0,0,       1,32'd32,1,32'd24,32'd24,1);
    add(1,1,1,32'd32,0,0,0,       1,32'd36,1,32'd24,32'd24,2);
    add(1,1,1,32'd36,0,0,0,       0,32'd40,1,32'd24,32'd24,3);
    add(1,1,0,0,0,0,0,            0,32'd40,1,32'd24,32'd24,4);
    add(1,1,0,0,0,0,0,            0,32'd40,1,32'd24,32'd24,4);
    add(1,1,0,0,1,0,0,            1,32'd40,1,32'd24,32'd24,4);
    add(1,1,0,0,0,0,0,            0,32'd44,1,32'd28,32'd28,3);
    add(1,1,1,32'd40,0,0,0,       0,32'd44,1,32'd28,32'd28,3);
    add(1,1,0,0,0,0,0,            0,32'd44,1,32'd28,32'd28,4);
    // redirect while WAIT, stale response 3 cycles later
    add(1,1,0,0,1,0,0,            1,32'd44,1,32'd28,32'd28,4);
    add(1,1,0,0,1,1,32'h103,      0,32'd48,1,32'd32,32'd32,3);
    add(1,1,0,0,1,0,0,            0,32'h100,0,32'd32,32'd32,0);
    add(1,1,0,0,1,0,0,            0,32'h100,0,32'd32,32'd32,0);
    add(1,1,1,32'd44,1,0,0,       0,32'h100,0,32'd32,32'd32,0);
    add(1,1,0,0,1,0,0,            1,32'h100,0,32'd32,32'd32,0);
    add(1,1,1,32'h100,1,0,0,      1,32'h104,0,32'd32,32'd32,0);
    // redirect together with rvalid and pop
    add(1,1,1,32'h104,1,1,32'h200, 0,32'h108,1,32'h100,32'h100,1);
    add(1,1,0,0,1,0,0,            1,32'h200,0,32'h100,32'h100,0);
    add(1,0,1,32'hDEAD_0200,1,0,0, 1,32'h204,0,32'h100,32'h100,0);
    add(1,0,0,0,0,0,0,            1,32'h204,1,32'h200,32'hDEAD_0200,1);
    // two entries queued with a request outstanding, then async reset
    add(1,1,0,0,0,0,0,            1,32'h204,1,32'h200,32'hDEAD_0200,1);
    add(1,1,1,32'hBEEF_0204,0,0,0, 1,32'h208,1,32'h200,32'hDEAD_0200,1);
    add(1,1,0,0,0,0,0,            0,32'h20C,1,32'h200,32'hDEAD_0200,2);
    add(0,1,0,0,0,0,0,            0,32'h0,0,0,0,0);
    // stray response after reset is ignored, fetch restarts at RESET_PC
    add(1,0,1,32'h55,1,0,0,       1,32'h0,0,0,0,0);
    add(1,1,0,0,1,0,0,            1,32'h0,0,0,0,0);
    add(1,0,1,32'h1234,0,0,0,     1,32'h4,0,0,0,0);
    add(1,0,0,0,0,0,0,            1,32'h4,1,32'h0,32'h1234,1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst; imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv;
      imem_rdata = vecs[i].rdata; inst_ready = vecs[i].rdy;
      redirect_valid = vecs[i].rdv; redirect_pc = vecs[i].rdpc;
      #1;
      chk("imem_req",   i, 32'(imem_req),   32'(vecs[i].e_req));
      chk("imem_addr",  i, imem_addr,       vecs[i].e_addr);
      chk("inst_valid", i, 32'(inst_valid), 32'(vecs[i].e_v));
      chk("inst_pc",    i, inst_pc,         vecs[i].e_pc);
      chk("inst_data",  i, inst_data,       vecs[i].e_data);
      chk("fifo_count", i, 32'(fifo_count), 32'(vecs[i].e_cnt));
    end

    // Redirect to the top word (low bits forced to 0) and check the fetch wraps to 0.
    @(negedge clk);
    imem_gnt = 1'b1; imem_rvalid = 1'b0; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    #1;
    chk("wrap_redir_req", 0, 32'(imem_req), 32'd0);
    pend = 1'b0; pend_addr = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      redirect_valid = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1;
      imem_rvalid = pend; imem_rdata = pend_addr ^ 32'h0F0F_0000;
      #1;
      if (inst_valid) begin
        dpc.push_back(inst_pc);
        ddat.push_back(inst_data);
      end
      if (imem_req) gq.push_back(imem_addr);
      pend = imem_req; pend_addr = imem_addr;
    end
    exp_g[0] = 32'hFFFF_FFFC; exp_g[1] = 32'h0; exp_g[2] = 32'h4; exp_g[3] = 32'h8;
    exp_p[0] = 32'hFFFF_FFFC; exp_p[1] = 32'h0; exp_p[2] = 32'h4;
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) chk("wrap_grant_addr", i, gq[i], exp_g[i]);
      else chk("wrap_grant_missing", i, 32'(gq.size()), 32'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      if (i < dpc.size()) begin
        chk("wrap_inst_pc", i, dpc[i], exp_p[i]);
        chk("wrap_inst_data", i, ddat[i], exp_p[i] ^ 32'h0F0F_0000);
      end else begin
        chk("wrap_delivery_missing", i, 32'(dpc.size()), 32'(i + 1));
      end
    end

    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
